dataframe_reader: RTL and testbench

- Consumer end of the header/footer and ADC FIFOs filled by the per-channel frame generator.
- Waits for a completed header/footer entry, then serialises one dataframe onto a DATAFRAME_WIDTH-wide AXI4-Stream:
  - header lines,
  - ADC payload lines, two per ADC word,
  - one footer line, carrying TLAST.
- Sits between the per-channel FIFOs and the channel merger/DMA path.

---
 rtl/dataframe_reader.sv | 171 +++++++++++++++++
 tb/tb_dataframe_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataframe_reader.sv
// Drains one header/footer FIFO entry plus its ADC payload words and serialises them
// as a single AXI4-Stream dataframe: header lines, two payload lines per ADC word, then the footer.
module dataframe_reader #(
    parameter int DATAFRAME_WIDTH  = 64,
    parameter int RFDC_TDATA_WIDTH = 128,
    parameter int HEADER_LINE      = 2,
    parameter int FOOTER_LINE      = 1,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                                                ACLK,
    input  logic                                                ARESETN,
    input  logic [(HEADER_LINE+FOOTER_LINE)*DATAFRAME_WIDTH-1:0] HF_FIFO_DOUT,
    input  logic                                                HF_FIFO_EMPTY,
    output logic                                                HF_FIFO_RD_EN,
    input  logic [RFDC_TDATA_WIDTH-1:0]                         ADC_FIFO_DOUT,
    input  logic                                                ADC_FIFO_EMPTY,
    output logic                                                ADC_FIFO_RD_EN,
    output logic [DATAFRAME_WIDTH-1:0]                          M_AXIS_TDATA,
    output logic                                                M_AXIS_TVALID,
    input  logic                                                M_AXIS_TREADY,
    output logic                                                M_AXIS_TLAST,
    output logic [31:0]                                         FRAME_COUNT,
    output logic                                                LEN_ERROR
);

    localparam int DW   = DATAFRAME_WIDTH;
    localparam int HF_W = (HEADER_LINE + FOOTER_LINE) * DW;
    localparam int IDXW = (HEADER_LINE > 1) ? $clog2(HEADER_LINE) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, DATA, FOOTER} state_t;

    state_t                 state_q, state_d;
    logic [HF_W-1:0]        hf_q, hf_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [IDXW-1:0]        hdr_idx_q, hdr_idx_d;
    logic                   phase_q, phase_d;
    logic                   footer_sent_q, footer_sent_d;
    logic [DW-1:0]          tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [31:0]            count_q, count_d;
    logic                   len_err_q, len_err_d;

    logic                   load_slot;
    logic                   accept;
    logic                   hf_pop;
    logic                   adc_pop;
    logic [LEN_WIDTH-1:0]   hf_len;
    logic [DW-1:0]          hdr_line [HEADER_LINE];

    for (genvar g = 0; g < HEADER_LINE; g++) begin : g_hdr
        assign hdr_line[g] = hf_q[HF_W-1-g*DW -: DW];
    end

    assign load_slot = !tvalid_q || M_AXIS_TREADY;
    assign accept    = tvalid_q && M_AXIS_TREADY && tlast_q;
    assign hf_len    = HF_FIFO_DOUT[HF_W-17 -: LEN_WIDTH];

    // The next entry is taken straight from FOOTER on acceptance so back-to-back frames
    // lose only one cycle; the IDLE path covers the first frame after a quiet period.
    assign hf_pop  = ARESETN && !HF_FIFO_EMPTY &&
                     ((state_q == IDLE) || ((state_q == FOOTER) && footer_sent_q && accept));
    assign adc_pop = ARESETN && (state_q == DATA) && phase_q && load_slot && !ADC_FIFO_EMPTY;

    always_comb begin
        state_d       = state_q;
        hf_d          = hf_q;
        len_d         = len_q;
        hdr_idx_d     = hdr_idx_q;
        phase_d       = phase_q;
        footer_sent_d = footer_sent_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        count_d       = count_q;
        len_err_d     = len_err_q;

        if (load_slot) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        unique case (state_q)
            HEADER: begin
                if (load_slot) begin
                    tdata_d  = hdr_line[hdr_idx_q];
                    tvalid_d = 1'b1;
                    if (hdr_idx_q == IDXW'(HEADER_LINE - 1)) begin
                        state_d = (len_q != '0) ? DATA : FOOTER;
                        phase_d = 1'b0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (load_slot && !ADC_FIFO_EMPTY) begin
                    tdata_d  = phase_q ? ADC_FIFO_DOUT[DW-1:0]
                                       : ADC_FIFO_DOUT[RFDC_TDATA_WIDTH-1 -: DW];
                    tvalid_d = 1'b1;
                    phase_d  = !phase_q;
                    len_d    = len_q - 1'b1;
                    if (len_q == LEN_WIDTH'(1)) begin
                        state_d = FOOTER;
                    end
                end
            end
            FOOTER: begin
                if (!footer_sent_q) begin
                    if (load_slot) begin
                        tdata_d       = hf_q[DW-1:0];
                        tvalid_d      = 1'b1;
                        tlast_d       = 1'b1;
                        footer_sent_d = 1'b1;
                    end
                end else if (accept) begin
                    count_d = count_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        if (hf_pop) begin
            hf_d          = HF_FIFO_DOUT;
            len_d         = {hf_len[LEN_WIDTH-1:1], 1'b0};
            len_err_d     = len_err_q | hf_len[0];
            hdr_idx_d     = '0;
            footer_sent_d = 1'b0;
            state_d       = HEADER;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            hf_q          <= '0;
            len_q         <= '0;
            hdr_idx_q     <= '0;
            phase_q       <= 1'b0;
            footer_sent_q <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            count_q       <= '0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hf_q          <= hf_d;
            len_q         <= len_d;
            hdr_idx_q     <= hdr_idx_d;
            phase_q       <= phase_d;
            footer_sent_q <= footer_sent_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            count_q       <= count_d;
            len_err_q     <= len_err_d;
        end
    end

    assign HF_FIFO_RD_EN  = hf_pop;
    assign ADC_FIFO_RD_EN = adc_pop;
    assign M_AXIS_TDATA   = tdata_q;
    assign M_AXIS_TVALID  = tvalid_q;
    assign M_AXIS_TLAST   = tlast_q;
    assign FRAME_COUNT    = count_q;
    assign LEN_ERROR      = len_err_q;

endmodule

// File: tb/tb_dataframe_reader.sv
// Bench for dataframe_reader: FWFT FIFO models feed random frames, a frame-level model
// predicts the beat sequence, and each scenario task checks its own results.
module tb_dataframe_reader;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [191:0] HF_FIFO_DOUT = '0;
    logic         HF_FIFO_EMPTY = 1'b1;
    logic         HF_FIFO_RD_EN;
    logic [127:0] ADC_FIFO_DOUT = '0;
    logic         ADC_FIFO_EMPTY = 1'b1;
    logic         ADC_FIFO_RD_EN;
    logic [63:0]  M_AXIS_TDATA;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY = 1'b0;
    logic         M_AXIS_TLAST;
    logic [31:0]  FRAME_COUNT;
    logic         LEN_ERROR;

    dataframe_reader #(
        .DATAFRAME_WIDTH (64),
        .RFDC_TDATA_WIDTH(128),
        .HEADER_LINE     (2),
        .FOOTER_LINE     (1),
        .LEN_WIDTH       (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .HF_FIFO_DOUT  (HF_FIFO_DOUT),
        .HF_FIFO_EMPTY (HF_FIFO_EMPTY),
        .HF_FIFO_RD_EN (HF_FIFO_RD_EN),
        .ADC_FIFO_DOUT (ADC_FIFO_DOUT),
        .ADC_FIFO_EMPTY(ADC_FIFO_EMPTY),
        .ADC_FIFO_RD_EN(ADC_FIFO_RD_EN),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .FRAME_COUNT   (FRAME_COUNT),
        .LEN_ERROR     (LEN_ERROR)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic [191:0] hf_mem[$];
    logic [127:0] adc_mem[$];
    beat_t        exp_q[$];
    beat_t        got_q[$];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  hf_pops = 0;
    int  adc_pops = 0;
    int  empty_pop_err = 0;
    int  hold_err = 0;
    int  hf_fall_cyc = 0;
    int  ready_mode = 0;
    int  exp_fc = 0;
    bit  adc_hold = 0;
    bit  hf_rd_s = 0;
    bit  adc_rd_s = 0;
    bit  stall = 0;
    logic [63:0] stall_data = '0;
    logic        stall_last = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // FIFO models: pop on the strobe seen before the edge, then present the new head.
    always begin
        @(posedge ACLK);
        #1;
        if (hf_rd_s) begin
            if (hf_mem.size() == 0) empty_pop_err++;
            else begin void'(hf_mem.pop_front()); hf_pops++; end
        end
        if (adc_rd_s) begin
            if (adc_mem.size() == 0) empty_pop_err++;
            else begin void'(adc_mem.pop_front()); adc_pops++; end
        end
        case (ready_mode)
            0:       M_AXIS_TREADY = 1'b1;
            1:       M_AXIS_TREADY = (cyc % 3 == 0);
            default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (HF_FIFO_EMPTY && hf_mem.size() != 0) hf_fall_cyc = cyc;
        HF_FIFO_EMPTY = (hf_mem.size() == 0);
        if (hf_mem.size() != 0) HF_FIFO_DOUT = hf_mem[0];
        ADC_FIFO_EMPTY = (adc_mem.size() == 0) || adc_hold;
        if (adc_mem.size() != 0) ADC_FIFO_DOUT = adc_mem[0];
    end

    always @(negedge ACLK) begin
        hf_rd_s  <= HF_FIFO_RD_EN;
        adc_rd_s <= ADC_FIFO_RD_EN;
        if (!ARESETN) begin
            stall <= 1'b0;
        end else begin
            if (stall && !(M_AXIS_TVALID === 1'b1 && M_AXIS_TDATA === stall_data &&
                           M_AXIS_TLAST === stall_last))
                hold_err <= hold_err + 1;
            if (M_AXIS_TVALID && M_AXIS_TREADY)
                got_q.push_back(beat_t'{M_AXIS_TDATA, M_AXIS_TLAST, cyc});
            stall      <= M_AXIS_TVALID && !M_AXIS_TREADY;
            stall_data <= M_AXIS_TDATA;
            stall_last <= M_AXIS_TLAST;
        end
    end

    // Builds a random frame, queues it in the FIFO models and appends the predicted beats.
    task automatic push_frame(input int len);
        logic [191:0] hf;
        logic [127:0] w;
        logic [127:0] words[$];
        int plen;
        hf = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        hf[175:160] = len[15:0];
        for (int i = 0; i < len / 2; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            words.push_back(w);
            adc_mem.push_back(w);
        end
        hf_mem.push_back(hf);
        exp_q.push_back(beat_t'{hf[191:128], 1'b0, 0});
        exp_q.push_back(beat_t'{hf[127:64], 1'b0, 0});
        plen = int'(hf[175:160]);
        plen = plen - (plen % 2);
        for (int k = 0; k < plen; k++) begin
            w = words[k / 2];
            exp_q.push_back(beat_t'{(k % 2 == 0) ? w[127:64] : w[63:0], 1'b0, 0});
        end
        exp_q.push_back(beat_t'{hf[63:0], 1'b1, 0});
    endtask

    task automatic wait_frames(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge ACLK);
            if (FRAME_COUNT == target) begin ok = 1; break; end
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge ACLK);
            if (got_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", M_AXIS_TVALID); end
        checks++; if (M_AXIS_TLAST !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", M_AXIS_TLAST); end
        checks++; if (M_AXIS_TDATA !== 64'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", M_AXIS_TDATA); end
        checks++; if (FRAME_COUNT !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", FRAME_COUNT); end
        checks++; if (LEN_ERROR !== 1'b0) begin failures++; $display("FAIL reset_lenerr got=%b exp=0", LEN_ERROR); end
        checks++; if (HF_FIFO_RD_EN !== 1'b0 || ADC_FIFO_RD_EN !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b%b exp=00", HF_FIFO_RD_EN, ADC_FIFO_RD_EN); end
    endtask

    task automatic test_basic;
        bit ok; int hp, ap;
        ready_mode = 0; exp_q.delete(); got_q.delete();
        hp = hf_pops; ap = adc_pops;
        push_frame(4);
        exp_fc++;
        wait_frames(exp_fc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout count=%0d exp=%0d", FRAME_COUNT, exp_fc); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                failures++; $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].cyc != hf_fall_cyc + 2) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", got_q[0].cyc - hf_fall_cyc, 2); end
        end
        checks++; if (hf_pops - hp != 1 || adc_pops - ap != 2) begin failures++; $display("FAIL basic_pops got=%0d/%0d exp=1/2", hf_pops - hp, adc_pops - ap); end
        checks++; if (FRAME_COUNT !== 32'(exp_fc)) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", FRAME_COUNT, exp_fc); end
        checks++; if (LEN_ERROR !== 1'b0) begin failures++; $display("FAIL basic_lenerr got=%b exp=0", LEN_ERROR); end
        checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL basic_idle_tvalid got=%b exp=0", M_AXIS_TVALID); end
    endtask

    task automatic test_zero_len;
        bit ok; int ap, ep;
        ready_mode = 0; exp_q.delete(); got_q.delete();
        ap = adc_pops; ep = empty_pop_err;
        push_frame(0);
        exp_fc++;
        wait_frames(exp_fc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL zero_timeout count=%0d exp=%0d", FRAME_COUNT, exp_fc); end
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL zero_beats got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                failures++; $display("FAIL zero_beat%0d got=%h/%b exp=%h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        checks++; if (adc_pops != ap || empty_pop_err != ep) begin failures++; $display("FAIL zero_adc_rd got=%0d/%0d exp=0/0", adc_pops - ap, empty_pop_err - ep); end
    endtask

    task automatic test_backpressure;
        bit ok; int hp, ap, he;
        for (int m = 1; m <= 2; m++) begin
            ready_mode = m; exp_q.delete(); got_q.delete();
            hp = hf_pops; ap = adc_pops; he = hold_err;
            push_frame(2 + 2 * m);
            exp_fc++;
            wait_frames(exp_fc, ok);
            checks++; if (!ok) begin failures++; $display("FAIL bp%0d_timeout count=%0d exp=%0d", m, FRAME_COUNT, exp_fc); end
            checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp%0d_beats got=%0d exp=%0d", m, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                    failures++; $display("FAIL bp%0d_beat%0d got=%h/%b exp=%h/%b", m, i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
                end
            end
            checks++; if (hold_err != he) begin failures++; $display("FAIL bp%0d_hold got=%0d exp=0", m, hold_err - he); end
            checks++; if (hf_pops - hp != 1 || adc_pops - ap != m + 1) begin failures++; $display("FAIL bp%0d_pops got=%0d/%0d exp=1/%0d", m, hf_pops - hp, adc_pops - ap, m + 1); end
        end
        ready_mode = 0;
    endtask

    task automatic test_adc_starvation;
        bit ok; int vcount;
        ready_mode = 0; exp_q.delete(); got_q.delete();
        adc_hold = 1;
        push_frame(4);
        exp_fc++;
        wait_beats(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL starve_header_timeout got=%0d exp=2", got_q.size()); end
        @(negedge ACLK);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (M_AXIS_TVALID) vcount++;
            @(negedge ACLK);
        end
        checks++; if (vcount != 0) begin failures++; $display("FAIL starve_tvalid got=%0d exp=0", vcount); end
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL starve_stalled got=%0d exp=2", got_q.size()); end
        adc_hold = 0;
        wait_frames(exp_fc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL starve_timeout count=%0d exp=%0d", FRAME_COUNT, exp_fc); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL starve_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                failures++; $display("FAIL starve_beat%0d got=%h/%b exp=%h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_odd_back_to_back;
        bit ok; int maxgap;
        ready_mode = 0; exp_q.delete(); got_q.delete();
        push_frame(3);
        exp_fc++;
        wait_frames(exp_fc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL odd_timeout count=%0d exp=%0d", FRAME_COUNT, exp_fc); end
        checks++; if (LEN_ERROR !== 1'b1) begin failures++; $display("FAIL odd_lenerr got=%b exp=1", LEN_ERROR); end
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL odd_beats got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                failures++; $display("FAIL odd_beat%0d got=%h/%b exp=%h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        exp_q.delete(); got_q.delete();
        push_frame(2);
        push_frame(2);
        exp_fc += 2;
        wait_frames(exp_fc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout count=%0d exp=%0d", FRAME_COUNT, exp_fc); end
        checks++; if (got_q.size() != 10) begin failures++; $display("FAIL b2b_beats got=%0d exp=10", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                failures++; $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        maxgap = 0;
        for (int i = 1; i < got_q.size(); i++)
            if (got_q[i].cyc - got_q[i-1].cyc > maxgap) maxgap = got_q[i].cyc - got_q[i-1].cyc;
        checks++; if (maxgap > 2) begin failures++; $display("FAIL b2b_gap got=%0d exp<=2", maxgap); end
        checks++; if (LEN_ERROR !== 1'b1) begin failures++; $display("FAIL b2b_lenerr_sticky got=%b exp=1", LEN_ERROR); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        ready_mode = 0; exp_q.delete(); got_q.delete();
        push_frame(8);
        wait_beats(4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_reach_data got=%0d exp=4", got_q.size()); end
        @(posedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        checks++; if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TDATA !== 64'd0) begin
            failures++; $display("FAIL rst_axis got=%b/%b/%h exp=0/0/0", M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA); end
        checks++; if (FRAME_COUNT !== 32'd0 || LEN_ERROR !== 1'b0) begin
            failures++; $display("FAIL rst_status got=%0d/%b exp=0/0", FRAME_COUNT, LEN_ERROR); end
        checks++; if (HF_FIFO_RD_EN !== 1'b0 || ADC_FIFO_RD_EN !== 1'b0) begin
            failures++; $display("FAIL rst_rden got=%b%b exp=00", HF_FIFO_RD_EN, ADC_FIFO_RD_EN); end
        hf_mem.delete(); adc_mem.delete(); exp_q.delete(); got_q.delete();
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        exp_fc = 1;
        push_frame(2);
        wait_frames(exp_fc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_after_timeout count=%0d exp=1", FRAME_COUNT); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_after_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                failures++; $display("FAIL rst_after_beat%0d got=%h/%b exp=%h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        checks++; if (FRAME_COUNT !== 32'd1) begin failures++; $display("FAIL rst_after_count got=%0d exp=1", FRAME_COUNT); end
        checks++; if (empty_pop_err != 0) begin failures++; $display("FAIL pop_on_empty got=%0d exp=0", empty_pop_err); end
    endtask

    initial begin
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        test_reset;
        test_basic;
        test_zero_len;
        test_backpressure;
        test_adc_starvation;
        test_odd_back_to_back;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
